// File: rtl/rule90_pkg.sv
// rtl/rule90_pkg.sv - shared width constant and state type for the rule90 engine
package rule90_pkg;

  // Default number of cells in the automaton row.
  localparam int DEFAULT_WIDTH = 512;

  // One full row of cells at the default width; bit i is cell i.
  typedef logic [DEFAULT_WIDTH-1:0] state_t;

endpackage : rule90_pkg

// File: rtl/rule90_cell.sv
// rtl/rule90_cell.sv - one rule 90 cell: state flop with reset/load/step mux
module rule90_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic d,
  input  logic left,
  input  logic right,
  output logic q
);

  // Reset beats load, load beats the neighbour XOR step.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else if (load) begin
      q <= d;
    end else begin
      q <= left ^ right;
    end
  end

endmodule : rule90_cell

// File: rtl/rule90.sv
// rtl/rule90.sv - rule 90 cellular-automaton pattern generator over WIDTH cells
module rule90
  import rule90_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] left_nb;
  logic [WIDTH-1:0] right_nb;

  // Cells beyond either end of the row read as constant zero, no wrap-around.
  assign left_nb  = {state[WIDTH-2:0], 1'b0};
  assign right_nb = {1'b0, state[WIDTH-1:1]};

  // One flop per cell; all cells step together from the pre-edge row.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    rule90_cell u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load),
      .d     (data[i]),
      .left  (left_nb[i]),
      .right (right_nb[i]),
      .q     (state[i])
    );
  end

  assign q = state;

endmodule : rule90

// File: tb/tb_rule90.sv
// tb/tb_rule90.sv - self-checking bench for rule90 with directed table and random model runs
module tb_rule90;
  import rule90_pkg::*;

  localparam int W = DEFAULT_WIDTH;

  logic   clk;
  logic   rst_n;
  logic   load;
  state_t data;
  state_t q;

  int checks;
  int errors;

  typedef struct {
    logic   rst_n;
    logic   load;
    state_t data;
    state_t exp;
    string  name;
  } vec_t;

  vec_t vecs[$];

  rule90 #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .data  (data),
    .q     (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic state_t bits1(input int a);
    state_t v;
    v = '0;
    v[a] = 1'b1;
    return v;
  endfunction

  function automatic state_t bits2(input int a, input int b);
    state_t v;
    v = bits1(a);
    v[b] = 1'b1;
    return v;
  endfunction

  function automatic state_t model_step(input state_t s);
    return (s >> 1) ^ (s << 1);
  endfunction

  function automatic state_t rand_row();
    state_t v;
    for (int w = 0; w < W / 32; w++) v[w*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic add(input logic r, input logic l, input state_t d, input state_t e, input string n);
    vec_t v;
    v.rst_n = r;
    v.load  = l;
    v.data  = d;
    v.exp   = e;
    v.name  = n;
    vecs.push_back(v);
  endtask

  task automatic check(input state_t exp, input string name);
    checks++;
    if (q !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, q, exp);
    end
  endtask

  task automatic apply(input logic r, input logic l, input state_t d);
    rst_n = r;
    load  = l;
    data  = d;
    @(posedge clk);
    #1;
  endtask

  state_t ones;
  state_t junk;
  state_t m;
  state_t ld;

  initial begin
    checks = 0;
    errors = 0;
    ones   = '1;
    junk   = '1;
    rst_n  = 1'b0;
    load   = 1'b1;
    data   = '1;

    // Reset wins over load, and holds while asserted.
    add(1'b0, 1'b1, ones, '0, "reset_over_load");
    add(1'b0, 1'b0, ones, '0, "reset_hold");
    // Single seed in the middle; data is junk on step edges and must be ignored.
    add(1'b1, 1'b1, bits1(256), bits1(256), "seed_load");
    add(1'b1, 1'b0, junk, bits2(255, 257), "seed_step1");
    add(1'b1, 1'b0, junk, bits2(254, 258), "seed_step2");
    add(1'b1, 1'b0, junk, bits2(253, 255) | bits2(257, 259), "seed_step3");
    add(1'b1, 1'b0, junk, bits2(252, 260), "seed_step4");
    // Row edges.
    add(1'b1, 1'b1, bits1(0), bits1(0), "edge0_load");
    add(1'b1, 1'b0, '0, bits1(1), "edge0_step");
    add(1'b1, 1'b1, bits1(511), bits1(511), "edge511_load");
    add(1'b1, 1'b0, '0, bits1(510), "edge511_step");
    add(1'b1, 1'b1, ones, ones, "ones_load");
    add(1'b1, 1'b0, '0, bits2(0, 511), "ones_step");
    // Load held for three edges with changing data, then stepping resumes.
    add(1'b1, 1'b1, bits1(7), bits1(7), "hold_load1");
    add(1'b1, 1'b1, bits2(30, 400), bits2(30, 400), "hold_load2");
    add(1'b1, 1'b1, bits2(100, 101), bits2(100, 101), "hold_load3");
    add(1'b1, 1'b0, '0, bits2(99, 100) | bits2(101, 102), "hold_resume");
    // Mid-run reset after four steps, then the zero row is a fixed point.
    add(1'b1, 1'b1, bits1(256), bits1(256), "mid_load");
    add(1'b1, 1'b0, '0, bits2(255, 257), "mid_step1");
    add(1'b1, 1'b0, '0, bits2(254, 258), "mid_step2");
    add(1'b1, 1'b0, '0, bits2(253, 255) | bits2(257, 259), "mid_step3");
    add(1'b1, 1'b0, '0, bits2(252, 260), "mid_step4");
    add(1'b0, 1'b0, junk, '0, "mid_reset");
    add(1'b1, 1'b0, junk, '0, "zero_fixed1");
    add(1'b1, 1'b0, junk, '0, "zero_fixed2");

    foreach (vecs[i]) begin
      apply(vecs[i].rst_n, vecs[i].load, vecs[i].data);
      check(vecs[i].exp, vecs[i].name);
    end

    // Seed walk continued ten generations against the shift-XOR model.
    apply(1'b1, 1'b1, bits1(256));
    m = bits1(256);
    check(m, "ref_load");
    for (int s = 0; s < 10; s++) begin
      apply(1'b1, 1'b0, rand_row());
      m = model_step(m);
      check(m, "ref_step");
    end

    // Random patterns, each run for fifty generations.
    for (int p = 0; p < 20; p++) begin
      ld = rand_row();
      apply(1'b1, 1'b1, ld);
      m = ld;
      check(m, "rand_load");
      for (int s = 0; s < 50; s++) begin
        apply(1'b1, 1'b0, rand_row());
        m = model_step(m);
        check(m, "rand_step");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_rule90
